// File: rtl/arilla_timer_responder_if.sv
// Shared arilla system bus. address is a word address; data, available and intercept
// are resolved nets so several responders and the initiator can share them.
interface arilla_bus_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic [AddrWidth-1:0]   address;
    logic [DataWidth/8-1:0] byte_enable;
    logic                   read;
    logic                   write;
    wire  [DataWidth-1:0]   data;
    wire                    available;
    wire                    intercept;

    modport responder (
        input  address, byte_enable, read, write, intercept,
        inout  data,
        output available
    );

    modport initiator (
        output address, byte_enable, read, write,
        inout  data,
        input  available, intercept
    );
endinterface

// File: rtl/arilla_timer_responder.sv
// RISC-V machine timer (mtime/mtimecmp/CTRL) as an arilla bus responder.
// Optional: ARILLA_TIMER_SNAPSHOT_EN adds a MTIME_HI shadow latched on MTIME_LO reads.
module arilla_timer_responder #(
    parameter logic [31:0] BaseAddress   = 32'h0200_0000,
    parameter int unsigned PrescaleWidth = 8,
    parameter int unsigned DataWidth     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    arilla_bus_if.responder bus,
    output logic            irq
);
    localparam int unsigned WordAddressWidth = 30;
    localparam logic [WordAddressWidth-1:0] BaseWord = BaseAddress[31:2];

    if (DataWidth != 32) begin : g_width_check
        $error("arilla_timer_responder: only DataWidth=32 is supported");
    end
    if (PrescaleWidth < 1 || PrescaleWidth > 30) begin : g_prescale_check
        $error("arilla_timer_responder: PrescaleWidth must be 1..30");
    end

    logic [63:0]              mtime_q, mtime_d;
    logic [63:0]              cmp_q, cmp_d;
    logic                     en_q, en_d;
    logic [PrescaleWidth-1:0] div_q, div_d;
    logic [PrescaleWidth-1:0] pre_q, pre_d;
    logic                     irq_q, irq_d;
`ifdef ARILLA_TIMER_SNAPSHOT_EN
    logic [31:0]              snap_q, snap_d;
`endif

    logic [2:0]  off;
    logic        base_match, hit, claim, wr_en, rd_en, tick;
    logic [31:0] wdata, rdata, ctrl_rd, ctrl_wr, hi_rd;
    logic [3:0]  be;

    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  lanes);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // Decode is gated by rst_n so the bus lines float while reset is held.
    assign off        = bus.address[2:0];
    assign base_match = (bus.address[WordAddressWidth-1:3] == BaseWord[WordAddressWidth-1:3]);
    assign hit        = rst_n && base_match && (off <= 3'd4);
    assign claim      = hit && (bus.read || bus.write);
    assign wr_en      = hit && bus.write;
    assign rd_en      = hit && bus.read && !bus.write;
    assign wdata      = bus.data;
    assign be         = bus.byte_enable;
    assign tick       = en_q && (pre_q == div_q);

    assign bus.data      = rd_en ? rdata : 'z;
    assign bus.available = claim ? 1'b1 : 1'bz;

    logic unused_bits;
    assign unused_bits = ^{bus.address[31:WordAddressWidth], ctrl_wr[31:PrescaleWidth+1],
                           bus.intercept};

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[PrescaleWidth:0] = {div_q, en_q};
`ifdef ARILLA_TIMER_SNAPSHOT_EN
        hi_rd = snap_q;
`else
        hi_rd = mtime_q[63:32];
`endif
        case (off)
            3'd0:    rdata = mtime_q[31:0];
            3'd1:    rdata = hi_rd;
            3'd2:    rdata = cmp_q[31:0];
            3'd3:    rdata = cmp_q[63:32];
            3'd4:    rdata = ctrl_rd;
            default: rdata = '0;
        endcase
    end

    // A bus write to mtime replaces the tick for that cycle; any mtime or CTRL write
    // restarts the prescaler so the next tick is a full divide period away.
    always_comb begin
        mtime_d = mtime_q;
        cmp_d   = cmp_q;
        en_d    = en_q;
        div_d   = div_q;
        pre_d   = pre_q;
        ctrl_wr = merge_be(ctrl_rd, wdata, be);
`ifdef ARILLA_TIMER_SNAPSHOT_EN
        snap_d  = snap_q;
        if (rd_en && off == 3'd0) snap_d = mtime_q[63:32];
`endif
        if (tick) begin
            mtime_d = mtime_q + 64'd1;
            pre_d   = '0;
        end else if (en_q) begin
            pre_d = pre_q + 1'b1;
        end
        if (wr_en) begin
            case (off)
                3'd0: begin
                    mtime_d = {mtime_q[63:32], merge_be(mtime_q[31:0], wdata, be)};
                    pre_d   = '0;
                end
                3'd1: begin
                    mtime_d = {merge_be(mtime_q[63:32], wdata, be), mtime_q[31:0]};
                    pre_d   = '0;
`ifdef ARILLA_TIMER_SNAPSHOT_EN
                    snap_d  = merge_be(mtime_q[63:32], wdata, be);
`endif
                end
                3'd2: cmp_d[31:0]  = merge_be(cmp_q[31:0], wdata, be);
                3'd3: cmp_d[63:32] = merge_be(cmp_q[63:32], wdata, be);
                3'd4: begin
                    en_d  = ctrl_wr[0];
                    div_d = ctrl_wr[PrescaleWidth:1];
                    pre_d = '0;
                end
                default: ;
            endcase
        end
        irq_d = (mtime_d >= cmp_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q <= '0;
            cmp_q   <= '1;
            en_q    <= 1'b0;
            div_q   <= '0;
            pre_q   <= '0;
            irq_q   <= 1'b0;
`ifdef ARILLA_TIMER_SNAPSHOT_EN
            snap_q  <= '0;
`endif
        end else begin
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            en_q    <= en_d;
            div_q   <= div_d;
            pre_q   <= pre_d;
            irq_q   <= irq_d;
`ifdef ARILLA_TIMER_SNAPSHOT_EN
            snap_q  <= snap_d;
`endif
        end
    end

    assign irq = irq_q;
endmodule

// File: tb/tb_arilla_timer_responder.sv
// Directed scoreboard bench for arilla_timer_responder: the driver queues expectations,
// a monitor checks every bus transfer at the falling edge.
module tb_arilla_timer_responder;
    localparam logic [31:0] BASE = 32'h0080_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq;
    logic tb_drv;
    logic [31:0] tb_wdata;

    always #5 clk = ~clk;

    arilla_bus_if #(32, 32) bus ();
    assign bus.data      = tb_drv ? tb_wdata : 'z;
    assign bus.intercept = 1'bz;

    arilla_timer_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .irq   (irq)
    );

    typedef struct {
        string       name;
        logic        avail;
        logic        chk_d;
        logic [31:0] data;
        logic        chk_i;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (bus.read === 1'b1 || bus.write === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_txn: got transfer at %0t, expected none", $time);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_avail"}, {31'b0, bus.available === 1'b1}, {31'b0, e.avail});
                    if (e.chk_d) chk({e.name, "_data"}, bus.data, e.data);
                    if (e.chk_i) chk({e.name, "_irq"}, {31'b0, irq}, {31'b0, e.irq});
                end
            end
        end
    end

    task automatic op(input string name, input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd, input logic exp_av,
                      input logic chk_d, input logic [31:0] exp_d, input logic chk_i,
                      input logic exp_i);
        exp_t x;
        @(posedge clk);
        #1;
        bus.address     = addr;
        bus.byte_enable = be;
        bus.read        = rd;
        bus.write       = wr;
        tb_drv          = wr;
        tb_wdata        = wd;
        x = '{name, exp_av, chk_d, exp_d, chk_i, exp_i};
        sb.push_back(x);
    endtask

    task automatic rdw(input string name, input logic [2:0] off, input logic [31:0] exp_d,
                       input logic chk_i, input logic exp_i);
        op(name, 1'b1, 1'b0, BASE + {29'b0, off}, 4'hF, 32'h0, 1'b1, 1'b1, exp_d, chk_i, exp_i);
    endtask

    task automatic wrw(input string name, input logic [2:0] off, input logic [31:0] d);
        op(name, 1'b0, 1'b1, BASE + {29'b0, off}, 4'hF, d, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.read  = 1'b0;
            bus.write = 1'b0;
            tb_drv    = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.address = '0; bus.byte_enable = '0; bus.read = 1'b0; bus.write = 1'b0;
        tb_drv = 1'b0; tb_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset values
        rdw("rst_mtime_lo", 3'd0, 32'h0, 1'b1, 1'b0);
        rdw("rst_mtime_hi", 3'd1, 32'h0, 1'b1, 1'b0);
        rdw("rst_cmp_lo", 3'd2, 32'hFFFF_FFFF, 1'b1, 1'b0);
        rdw("rst_cmp_hi", 3'd3, 32'hFFFF_FFFF, 1'b1, 1'b0);
        rdw("rst_ctrl", 3'd4, 32'h0, 1'b1, 1'b0);

        // CTRL keeps only enable+divide
        wrw("ctrl_mask_w", 3'd4, 32'hFFFF_FFFE);
        rdw("ctrl_mask_r", 3'd4, 32'h0000_01FE, 1'b0, 1'b0);
        wrw("ctrl_off", 3'd4, 32'h0);

        // divide 0: one tick per cycle after the CTRL write
        wrw("ctrl_div0", 3'd4, 32'h1);
        idle(10);
        rdw("count_div0", 3'd0, 32'd10, 1'b0, 1'b0);

        // divide 3: one tick per 4 cycles
        wrw("freeze_a", 3'd4, 32'h0);
        wrw("mt_lo0_a", 3'd0, 32'h0);
        wrw("mt_hi0_a", 3'd1, 32'h0);
        wrw("ctrl_div3", 3'd4, 32'h7);
        idle(12);
        rdw("count_div3_a", 3'd0, 32'd3, 1'b0, 1'b0);
        idle(3);
        rdw("count_div3_b", 3'd0, 32'd4, 1'b0, 1'b0);

        // wrap through all-ones
        wrw("freeze_b", 3'd4, 32'h0);
        wrw("mt_lo_fe", 3'd0, 32'hFFFF_FFFE);
        wrw("mt_hi_ff", 3'd1, 32'hFFFF_FFFF);
        rdw("wrap_pre", 3'd0, 32'hFFFF_FFFE, 1'b1, 1'b0);
        wrw("ctrl_wrap", 3'd4, 32'h1);
        rdw("wrap_t0", 3'd0, 32'hFFFF_FFFE, 1'b1, 1'b0);
        rdw("wrap_t1", 3'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);
        rdw("wrap_t2", 3'd0, 32'h0, 1'b1, 1'b0);
        rdw("wrap_hi", 3'd1, 32'h0, 1'b1, 1'b0);

        // compare at 5
        wrw("freeze_c", 3'd4, 32'h0);
        wrw("mt_lo0_c", 3'd0, 32'h0);
        wrw("mt_hi0_c", 3'd1, 32'h0);
        wrw("cmp_hi0", 3'd3, 32'h0);
        wrw("cmp_lo5", 3'd2, 32'h5);
        wrw("ctrl_cmp", 3'd4, 32'h1);
        idle(4);
        rdw("cmp_at4", 3'd0, 32'd4, 1'b1, 1'b0);
        rdw("cmp_at5", 3'd0, 32'd5, 1'b1, 1'b1);
        op("cmp_hi1", 1'b0, 1'b1, BASE + 32'd3, 4'hF, 32'h1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        rdw("cmp_clear", 3'd0, 32'd7, 1'b1, 1'b0);

        // byte lanes
        wrw("freeze_d", 3'd4, 32'h0);
        op("be_w", 1'b0, 1'b1, BASE + 32'd2, 4'b0010, 32'hAABB_CCDD, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        rdw("be_cmp_lo", 3'd2, 32'h0000_CC05, 1'b0, 1'b0);
        rdw("be_cmp_hi", 3'd3, 32'h0000_0001, 1'b0, 1'b0);

        // unclaimed addresses
        op("off5_rd", 1'b1, 1'b0, BASE + 32'd5, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        op("off5_wr", 1'b0, 1'b1, BASE + 32'd5, 4'hF, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        op("off7_rd", 1'b1, 1'b0, BASE + 32'd7, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        op("other_rd", 1'b1, 1'b0, BASE + 32'd10, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rdw("no_alias", 3'd2, 32'h0000_CC05, 1'b0, 1'b0);

        // read+write together acts as a write and the responder leaves data alone
        op("rdwr", 1'b1, 1'b1, BASE + 32'd2, 4'hF, 32'h0000_1234, 1'b1, 1'b1, 32'h0000_1234,
           1'b0, 1'b0);
        rdw("rdwr_back", 3'd2, 32'h0000_1234, 1'b0, 1'b0);

        // LO-then-HI across a carry
        wrw("freeze_e", 3'd4, 32'h0);
        wrw("snap_lo", 3'd0, 32'hFFFF_FFFF);
        wrw("snap_hi", 3'd1, 32'h0);
        wrw("ctrl_snap", 3'd4, 32'h1);
        rdw("snap_rd_lo", 3'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
`ifdef ARILLA_TIMER_SNAPSHOT_EN
        rdw("snap_rd_hi", 3'd1, 32'h0, 1'b0, 1'b0);
`else
        rdw("snap_rd_hi", 3'd1, 32'h1, 1'b0, 1'b0);
`endif

        // reset in the middle of a write
        wrw("freeze_f", 3'd4, 32'h0);
        op("rst_wr", 1'b0, 1'b1, BASE + 32'd2, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        rdw("post_rst_cmp_lo", 3'd2, 32'hFFFF_FFFF, 1'b1, 1'b0);
        rdw("post_rst_cmp_hi", 3'd3, 32'hFFFF_FFFF, 1'b1, 1'b0);
        rdw("post_rst_mt_lo", 3'd0, 32'h0, 1'b1, 1'b0);
        rdw("post_rst_ctrl", 3'd4, 32'h0, 1'b1, 1'b0);
        idle(3);

        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
